multi_channel_ds_pwm_driver: RTL and testbench
==============================================

# multi_channel_ds_pwm_driver

Parametrised center-aligned (dual-slope) PWM generator for N half-bridge channels, with complementary high/low outputs, dead-time insertion, double-buffered duty registers and a latched fault state. It sits downstream of the space-vector modulator and drives the gate-driver pins directly. It supersedes the fixed three-channel, single-output dual-slope driver.

## Interface
Parameters:
- CHANNELS, 3, number of half-bridge channels
- DATA_WIDTH, 16, width of each unsigned duty word
- PERIOD, 100, PWM period in clk cycles; must be even, ≥ 4
- MAX_ON_CYCLES, 95, duty clamp; must be ≤ PERIOD - 1
- DEAD_TIME, 2, dead-time in clk cycles, 0..15

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trigger  in  1  period-start request, one-cycle pulse
- fault  in  1  external fault, level, active-high
- fault_clear  in  1  clears latched fault, one-cycle pulse
- pwm_valid  in  1  pwm_data strobe
- pwm_data  in  CHANNELS*DATA_WIDTH  duty words, channel 0 in MSBs
- driver_pwm_h  out  CHANNELS  high-side gate enables
- driver_pwm_l  out  CHANNELS  low-side gate enables
- status_running  out  1  high in RUN
- status_fault  out  1  high in FAULT

## Operation
- States: IDLE, RUN, FAULT. Reset → IDLE.
- Pending register (per channel): loaded from pwm_data on pwm_valid, any state. Reset value 0.
- Active register (per channel): loaded from pending when a period starts (IDLE→RUN, or RUN wrap). A pwm_valid in the same cycle as a period start goes to pending only and takes effect next period.
- Clamp at load: active = min(pending, MAX_ON_CYCLES), unsigned compare at DATA_WIDTH.
- Phase counter p, width $clog2(PERIOD), counts 0..PERIOD-1. HALF = PERIOD/2.
- Raw on for channel n iff HALF - floor(d/2) ≤ p < HALF + ceil(d/2), where d = active duty. On-width is exactly d cycles, centered on HALF.
- Dead time: raw_d is raw delayed DEAD_TIME cycles. raw_d is 0 when outside RUN.
  - h = raw & raw_d
  - l = ~raw & ~raw_d
  - DEAD_TIME = 0 gives h = raw and l = ~raw.
- IDLE: all outputs low. On trigger → RUN, p = 0.
- RUN:
  - p increments each cycle.
  - A trigger seen while p ≠ PERIOD-1 sets trigger_pending.
  - At p = PERIOD-1: if trigger_pending or trigger, wrap to p = 0 with no gap and clear trigger_pending; else → IDLE.
- FAULT:
  - Entered from any state on the cycle after fault is sampled high. fault has priority over trigger.
  - In FAULT: outputs low, delay line and trigger_pending cleared.
  - Stays in FAULT while fault is high. fault_clear with fault low → IDLE. Trigger is ignored in FAULT.

## Timing
- All outputs are registered. Reset values:
  - driver_pwm_h = 0, driver_pwm_l = 0
  - status_running = 0, status_fault = 0
- trigger sampled at edge E → p = 0 from E. Outputs reflect phase p one cycle later (latency 1).
- Fault response: fault high at edge E → state FAULT at E, outputs low after E+1. Worst-case latency is 2 edges.
- h and l are never high simultaneously for a channel, in any state.
- Reset mid-RUN: next cycle in IDLE, outputs low. Pending, active and trigger_pending are cleared.
- Back-to-back triggers every PERIOD cycles give continuous periods with no idle cycle.

## Test plan
- **Nominal duty:** PERIOD=100, DEAD_TIME=2, all duties 50, trigger.
  - h high for p 27..74 (48 cycles).
  - l high for p 0..24 and 77..99.
  - Both low at p 25–26 and 75–76.
  - One-cycle output latency.
- **Clamp:** duty 200.
  - raw on for p 3..97 (95 cycles).
  - h high 93 cycles.
- **Zero duty:** duty 0 → h never high; l high all 100 cycles.
- **Double buffering:** pwm_valid=30 at p=40 of a period with duty 50.
  - The current period keeps 50.
  - A retrigger at p=60 starts the next period with no gap, and that period uses 30.
- **Fault:** fault high at p=30, held 5 cycles, then fault_clear.
  - Outputs low within 2 edges; status_fault=1.
  - A trigger during fault is ignored.
  - After clear → IDLE; a new trigger runs normally.
- **Reset and channel independence:** reset asserted mid-RUN with CHANNELS=4 and duties 10/20/30/40.
  - Outputs low next cycle and pending cleared.
  - After release, a trigger with no pwm_valid gives zero duty on all channels.

Source files
------------

// File: rtl/multi_channel_ds_pwm_driver.sv
// Center-aligned (dual-slope) PWM driver for CHANNELS half-bridges.
// Each channel has complementary high/low gate enables with dead-time,
// double-buffered duty words and a latched fault state.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no period running, all gate enables low, waiting for trigger
// S_RUN   | phase counter sweeping 0..PERIOD-1, gates follow active duty
// S_FAULT | latched fault, gates low, left only by fault_clear (fault low)

module multi_channel_ds_pwm_driver #(
  parameter int CHANNELS      = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int PERIOD        = 100,
  parameter int MAX_ON_CYCLES = 95,
  parameter int DEAD_TIME     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           trigger,
  input  logic                           fault,
  input  logic                           fault_clear,
  input  logic                           pwm_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] pwm_data,
  output logic [CHANNELS-1:0]            driver_pwm_h,
  output logic [CHANNELS-1:0]            driver_pwm_l,
  output logic                           status_running,
  output logic                           status_fault
);

  // Phase counter width, plus one extra bit for the on-window bounds:
  // the upper bound can reach PERIOD itself.
  localparam int CW   = $clog2(PERIOD);
  localparam int AW   = CW + 1;
  localparam int HALF = PERIOD / 2;

  localparam logic [CW-1:0]         P_LAST = CW'(PERIOD - 1);
  localparam logic [AW-1:0]         HALF_A = AW'(HALF);
  localparam logic [DATA_WIDTH-1:0] MAX_D  = DATA_WIDTH'(MAX_ON_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                  state;
  logic [CW-1:0]           phase;
  logic [AW-1:0]           phase_ext;
  logic                    trig_pend;
  logic                    run;
  logic                    period_start;

  logic [DATA_WIDTH-1:0]   pending [CHANNELS];
  logic [AW-1:0]           active  [CHANNELS];

  logic [CHANNELS-1:0]     raw;
  logic [CHANNELS-1:0]     raw_d;

  assign run       = (state == S_RUN);
  assign phase_ext = {1'b0, phase};

  // Clamped duty always fits in AW bits because MAX_ON_CYCLES < PERIOD.
  function automatic logic [AW-1:0] clamp_duty(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] c;
    c = (d > MAX_D) ? MAX_D : d;
    return AW'(c);
  endfunction

  // A new period begins on a trigger from idle or on a wrap at the last phase;
  // fault overrides both.
  always_comb begin
    period_start = 1'b0;
    if (!fault) begin
      if (state == S_IDLE && trigger) begin
        period_start = 1'b1;
      end else if (state == S_RUN && phase == P_LAST && (trig_pend || trigger)) begin
        period_start = 1'b1;
      end
    end
  end

  // Main FSM: state, phase counter, trigger memory and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      phase          <= '0;
      trig_pend      <= 1'b0;
      status_running <= 1'b0;
      status_fault   <= 1'b0;
    end else if (fault) begin
      state          <= S_FAULT;
      phase          <= '0;
      trig_pend      <= 1'b0;
      status_running <= 1'b0;
      status_fault   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          phase     <= '0;
          trig_pend <= 1'b0;
          if (trigger) begin
            state          <= S_RUN;
            status_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (phase == P_LAST) begin
            phase     <= '0;
            trig_pend <= 1'b0;
            if (!(trig_pend || trigger)) begin
              state          <= S_IDLE;
              status_running <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
            if (trigger) begin
              trig_pend <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          phase     <= '0;
          trig_pend <= 1'b0;
          if (fault_clear) begin
            state        <= S_IDLE;
            status_fault <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          phase          <= '0;
          trig_pend      <= 1'b0;
          status_running <= 1'b0;
          status_fault   <= 1'b0;
        end
      endcase
    end
  end

  // Duty double buffer: pending takes host writes at any time, active only
  // changes at a period start, so a write never tears a running period.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < CHANNELS; n++) begin
        pending[n] <= '0;
        active[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (pwm_valid) begin
          pending[n] <= pwm_data[(CHANNELS-1-n)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (period_start) begin
          active[n] <= clamp_duty(pending[n]);
        end
      end
    end
  end

  // Per-channel on-window: floor(d/2) cycles before HALF, ceil(d/2) from HALF.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    assign lo     = HALF_A - (active[n] >> 1);
    assign hi     = HALF_A + active[n] - (active[n] >> 1);
    assign raw[n] = run && (phase_ext >= lo) && (phase_ext < hi);
  end

  // Dead-time delay line; rising edges of h and l are both pushed out by
  // DEAD_TIME because each side needs raw and its delayed copy to agree.
  if (DEAD_TIME == 0) begin : g_no_dt
    assign raw_d = raw;
  end else begin : g_dt
    logic [CHANNELS-1:0] dl [DEAD_TIME];

    // Shift raw through DEAD_TIME stages, flushed on reset and while faulted.
    always_ff @(posedge clk) begin
      if (reset || state == S_FAULT) begin
        for (int k = 0; k < DEAD_TIME; k++) begin
          dl[k] <= '0;
        end
      end else begin
        dl[0] <= raw;
        for (int k = 1; k < DEAD_TIME; k++) begin
          dl[k] <= dl[k-1];
        end
      end
    end

    assign raw_d = run ? dl[DEAD_TIME-1] : '0;
  end

  // Registered gate enables; both sides held low outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      driver_pwm_h <= '0;
      driver_pwm_l <= '0;
    end else if (run) begin
      driver_pwm_h <= raw & raw_d;
      driver_pwm_l <= ~raw & ~raw_d;
    end else begin
      driver_pwm_h <= '0;
      driver_pwm_l <= '0;
    end
  end

endmodule

// File: tb/tb_multi_channel_ds_pwm_driver.sv
// Directed bench for multi_channel_ds_pwm_driver (4 channels, PERIOD 100,
// dead-time 2). Expected outputs are queued when each cycle's stimulus is
// driven and popped when the registered outputs appear.

module tb_multi_channel_ds_pwm_driver;

  localparam int C     = 4;
  localparam int DW    = 16;
  localparam int PER   = 100;
  localparam int MAXON = 95;
  localparam int DT    = 2;
  localparam int HALF  = PER / 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            trigger;
  logic            fault;
  logic            fault_clear;
  logic            pwm_valid;
  logic [C*DW-1:0] pwm_data;
  logic [C-1:0]    driver_pwm_h;
  logic [C-1:0]    driver_pwm_l;
  logic            status_running;
  logic            status_fault;

  int checks = 0;
  int errors = 0;
  int d_cur [C];
  int h_cnt;
  int l_cnt;

  logic [C-1:0] q_h [$];
  logic [C-1:0] q_l [$];
  logic         q_r [$];
  logic         q_f [$];
  string        q_t [$];

  multi_channel_ds_pwm_driver #(
    .CHANNELS(C), .DATA_WIDTH(DW), .PERIOD(PER),
    .MAX_ON_CYCLES(MAXON), .DEAD_TIME(DT)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .fault(fault),
    .fault_clear(fault_clear), .pwm_valid(pwm_valid), .pwm_data(pwm_data),
    .driver_pwm_h(driver_pwm_h), .driver_pwm_l(driver_pwm_l),
    .status_running(status_running), .status_fault(status_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic logic raw_f(input int p, input int d);
    return (p >= HALF - d / 2) && (p < HALF + (d + 1) / 2);
  endfunction

  function automatic logic del_f(input int p, input int d);
    return (p >= DT) && raw_f(p - DT, d);
  endfunction

  function automatic logic [C-1:0] hv(input int p);
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = raw_f(p, d_cur[c]) && del_f(p, d_cur[c]);
    return v;
  endfunction

  function automatic logic [C-1:0] lv(input int p);
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = !raw_f(p, d_cur[c]) && !del_f(p, d_cur[c]);
    return v;
  endfunction

  function automatic logic [C*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {DW'(a), DW'(b), DW'(c), DW'(d)};
  endfunction

  task automatic cmp(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: queue the expectation, clock, then compare at the falling edge.
  task automatic step(input logic [C-1:0] eh, input logic [C-1:0] el,
                      input logic er, input logic ef, input string tag);
    logic [C-1:0] xh;
    logic [C-1:0] xl;
    logic         xr;
    logic         xf;
    string        xt;
    q_h.push_back(eh);
    q_l.push_back(el);
    q_r.push_back(er);
    q_f.push_back(ef);
    q_t.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    xh = q_h.pop_front();
    xl = q_l.pop_front();
    xr = q_r.pop_front();
    xf = q_f.pop_front();
    xt = q_t.pop_front();
    cmp(32'(driver_pwm_h), 32'(xh), {xt, " h"});
    cmp(32'(driver_pwm_l), 32'(xl), {xt, " l"});
    cmp(32'(status_running), 32'(xr), {xt, " running"});
    cmp(32'(status_fault), 32'(xf), {xt, " fault"});
    if (driver_pwm_h[0]) h_cnt++;
    if (driver_pwm_l[0]) l_cnt++;
    trigger     = 1'b0;
    pwm_valid   = 1'b0;
    fault_clear = 1'b0;
  endtask

  task automatic chk_phase(input int p, input logic er, input string tag);
    step(hv(p), lv(p), er, 1'b0, $sformatf("%s p%0d", tag, p));
  endtask

  task automatic quiet(input logic er, input logic ef, input string tag);
    step('0, '0, er, ef, tag);
  endtask

  initial begin
    reset       = 1'b1;
    trigger     = 1'b0;
    fault       = 1'b0;
    fault_clear = 1'b0;
    pwm_valid   = 1'b0;
    pwm_data    = '0;
    d_cur       = '{0, 0, 0, 0};
    h_cnt       = 0;
    l_cnt       = 0;

    quiet(0, 0, "reset0");
    quiet(0, 0, "reset1");
    reset = 1'b0;

    // Nominal: duty 50 on all channels.
    pwm_valid = 1'b1; pwm_data = pack4(50, 50, 50, 50);
    quiet(0, 0, "nom load");
    trigger = 1'b1;
    quiet(1, 0, "nom trig");
    d_cur = '{50, 50, 50, 50}; h_cnt = 0; l_cnt = 0;
    for (int p = 0; p < PER; p++) chk_phase(p, p != PER - 1, "nom");
    cmp(32'(h_cnt), 32'd48, "nom h width");
    cmp(32'(l_cnt), 32'd48, "nom l width");
    quiet(0, 0, "nom end");

    // Clamp: every value above MAX_ON_CYCLES, and the limit itself, gives 95.
    pwm_valid = 1'b1; pwm_data = pack4(200, 95, 96, 65535);
    quiet(0, 0, "clamp load");
    trigger = 1'b1;
    quiet(1, 0, "clamp trig");
    d_cur = '{95, 95, 95, 95}; h_cnt = 0; l_cnt = 0;
    for (int p = 0; p < PER; p++) chk_phase(p, p != PER - 1, "clamp");
    cmp(32'(h_cnt), 32'd93, "clamp h width");
    cmp(32'(l_cnt), 32'd3, "clamp l width");
    quiet(0, 0, "clamp end");

    // Tiny duties; a write coinciding with the trigger only lands next period,
    // and a trigger at the last phase wraps without a gap.
    pwm_valid = 1'b1; pwm_data = pack4(0, 1, 2, 3);
    quiet(0, 0, "small load");
    trigger = 1'b1; pwm_valid = 1'b1; pwm_data = pack4(60, 60, 60, 60);
    quiet(1, 0, "small trig");
    d_cur = '{0, 1, 2, 3}; h_cnt = 0; l_cnt = 0;
    for (int p = 0; p < PER; p++) begin
      if (p == PER - 1) trigger = 1'b1;
      chk_phase(p, 1'b1, "small");
    end
    cmp(32'(h_cnt), 32'd0, "zero h width");
    cmp(32'(l_cnt), 32'd100, "zero l width");
    d_cur = '{60, 60, 60, 60};
    for (int p = 0; p < PER; p++) chk_phase(p, p != PER - 1, "b2b");
    quiet(0, 0, "b2b end");

    // Double buffering: write at p40, retrigger at p60.
    pwm_valid = 1'b1; pwm_data = pack4(50, 50, 50, 50);
    quiet(0, 0, "dbuf load");
    trigger = 1'b1;
    quiet(1, 0, "dbuf trig");
    d_cur = '{50, 50, 50, 50};
    for (int p = 0; p < PER; p++) begin
      if (p == 40) begin pwm_valid = 1'b1; pwm_data = pack4(30, 30, 30, 30); end
      if (p == 60) trigger = 1'b1;
      chk_phase(p, 1'b1, "dbuf cur");
    end
    d_cur = '{30, 30, 30, 30};
    for (int p = 0; p < PER; p++) chk_phase(p, p != PER - 1, "dbuf next");
    quiet(0, 0, "dbuf end");

    // Fault at p30, held 5 cycles, triggers ignored, then cleared.
    trigger = 1'b1;
    quiet(1, 0, "flt trig");
    for (int p = 0; p < 30; p++) chk_phase(p, 1'b1, "pre flt");
    fault = 1'b1;
    step(hv(30), lv(30), 0, 1, "flt edge");
    quiet(0, 1, "flt low");
    trigger = 1'b1;
    quiet(0, 1, "flt trig ign");
    fault_clear = 1'b1;
    quiet(0, 1, "flt clr while high");
    quiet(0, 1, "flt hold");
    fault = 1'b0;
    trigger = 1'b1;
    quiet(0, 1, "flt trig ign low");
    quiet(0, 1, "flt latched");
    fault_clear = 1'b1;
    quiet(0, 0, "flt clear");
    quiet(0, 0, "flt idle");
    fault = 1'b1; trigger = 1'b1;
    quiet(0, 1, "flt prio");
    fault = 1'b0; fault_clear = 1'b1;
    quiet(0, 0, "flt clear2");
    trigger = 1'b1;
    quiet(1, 0, "post flt trig");
    for (int p = 0; p < PER; p++) chk_phase(p, p != PER - 1, "post flt");
    quiet(0, 0, "post flt end");

    // Independent channels, then reset mid-run with a pending retrigger.
    pwm_valid = 1'b1; pwm_data = pack4(10, 20, 30, 40);
    quiet(0, 0, "ind load");
    trigger = 1'b1;
    quiet(1, 0, "ind trig");
    d_cur = '{10, 20, 30, 40};
    for (int p = 0; p < 60; p++) begin
      if (p == 50) trigger = 1'b1;
      chk_phase(p, 1'b1, "ind");
    end
    reset = 1'b1;
    quiet(0, 0, "rst mid");
    reset = 1'b0;
    quiet(0, 0, "rst idle");
    trigger = 1'b1;
    quiet(1, 0, "rst trig");
    d_cur = '{0, 0, 0, 0}; h_cnt = 0; l_cnt = 0;
    for (int p = 0; p < PER; p++) chk_phase(p, p != PER - 1, "rst zero");
    cmp(32'(l_cnt), 32'd100, "rst zero l width");
    quiet(0, 0, "rst end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
